reservation_station: RTL and testbench

Arithmetic/branch reservation station feeding the out-of-order core's ALU. Holds issued ALU-class instructions (arith, imm-arith, branch, JAL, JALR, LUI, AUIPC) until both source operands are available. Snoops the ALU and LSB result broadcasts to wake waiting operands, then dispatches one ready entry per cycle on the `rs_to_alu_*` interface. The ALU's broadcast returns here as a wakeup source.

---
 rtl/reservation_station_pkg.sv | 74 +++++++
 rtl/reservation_station_if.sv | 52 +++++
 rtl/reservation_station_prio_enc.sv | 21 ++
 rtl/reservation_station.sv | 99 +++++++++
 tb/tb_reservation_station.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode encodings and entry/broadcast/dispatch records for the
// ALU reservation station.
package reservation_station_pkg;
    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = $clog2(RS_SIZE);
    localparam int ROB_POS_W = 5;
    localparam int OPENUM_W  = 6;
    localparam int DATA_TYPE = 32;
    localparam int ADDR_TYPE = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [OPENUM_W-1:0]  openum_t;
    typedef logic [ROB_POS_W-1:0] rob_pos_t;
    typedef logic [DATA_TYPE-1:0] data_t;
    typedef logic [ADDR_TYPE-1:0] addr_t;

    localparam openum_t OPENUM_NOP   = 6'd0;
    localparam openum_t OPENUM_ADD   = 6'd1;
    localparam openum_t OPENUM_SUB   = 6'd2;
    localparam openum_t OPENUM_ADDI  = 6'd3;
    localparam openum_t OPENUM_BEQ   = 6'd4;
    localparam openum_t OPENUM_BNE   = 6'd5;
    localparam openum_t OPENUM_JAL   = 6'd6;
    localparam openum_t OPENUM_JALR  = 6'd7;
    localparam openum_t OPENUM_LUI   = 6'd8;
    localparam openum_t OPENUM_AUIPC = 6'd9;

    typedef struct packed {
        logic     rely;
        rob_pos_t tag;
        data_t    val;
    } opnd_t;

    typedef struct packed {
        logic     busy;
        openum_t  op;
        rob_pos_t rob_pos;
        opnd_t    rs1;
        opnd_t    rs2;
        data_t    imm;
        addr_t    pc;
    } rs_entry_t;

    typedef struct packed {
        logic     en;
        rob_pos_t rob_pos;
        data_t    val;
    } bcast_t;

    typedef struct packed {
        openum_t  op;
        rob_pos_t rob_pos;
        data_t    rs1_val;
        data_t    rs2_val;
        data_t    imm;
        addr_t    pc;
    } disp_t;

    // Resolve a pending operand against both result buses; ALU wins a tie.
    function automatic opnd_t snoop(opnd_t o, bcast_t a, bcast_t l);
        opnd_t r;
        r = o;
        if (o.rely && a.en && a.rob_pos == o.tag) begin
            r.rely = FALSE;
            r.val  = a.val;
        end else if (o.rely && l.en && l.rob_pos == o.tag) begin
            r.rely = FALSE;
            r.val  = l.val;
        end
        return r;
    endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Issue, wakeup-broadcast and ALU-dispatch signals of the reservation station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic     issue_enable;
    openum_t  issue_openum;
    rob_pos_t issue_rob_pos;
    logic     issue_rs1_rely;
    rob_pos_t issue_rs1_tag;
    data_t    issue_rs1_val;
    logic     issue_rs2_rely;
    rob_pos_t issue_rs2_tag;
    data_t    issue_rs2_val;
    data_t    issue_imm;
    addr_t    issue_pc;
    logic     rs_full;

    logic     alu_broadcast_enable;
    rob_pos_t alu_broadcast_rob_pos;
    data_t    alu_broadcast_val;
    logic     lsb_broadcast_enable;
    rob_pos_t lsb_broadcast_rob_pos;
    data_t    lsb_broadcast_val;

    logic     rs_to_alu_enable;
    openum_t  rs_to_alu_openum;
    rob_pos_t rs_to_alu_rob_pos;
    data_t    rs_to_alu_rs1_val;
    data_t    rs_to_alu_rs2_val;
    data_t    rs_to_alu_imm;
    addr_t    rs_to_alu_pc;

    modport slave (
        input  issue_enable, issue_openum, issue_rob_pos,
               issue_rs1_rely, issue_rs1_tag, issue_rs1_val,
               issue_rs2_rely, issue_rs2_tag, issue_rs2_val, issue_imm, issue_pc,
               alu_broadcast_enable, alu_broadcast_rob_pos, alu_broadcast_val,
               lsb_broadcast_enable, lsb_broadcast_rob_pos, lsb_broadcast_val,
        output rs_full, rs_to_alu_enable, rs_to_alu_openum, rs_to_alu_rob_pos,
               rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_pc
    );

    modport master (
        output issue_enable, issue_openum, issue_rob_pos,
               issue_rs1_rely, issue_rs1_tag, issue_rs1_val,
               issue_rs2_rely, issue_rs2_tag, issue_rs2_val, issue_imm, issue_pc,
               alu_broadcast_enable, alu_broadcast_rob_pos, alu_broadcast_val,
               lsb_broadcast_enable, lsb_broadcast_rob_pos, lsb_broadcast_val,
        input  rs_full, rs_to_alu_enable, rs_to_alu_openum, rs_to_alu_rob_pos,
               rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_pc
    );
endinterface

// File: rtl/reservation_station_prio_enc.sv
// Lowest-set-bit priority encoder: index of the first asserted bit plus a found flag.
module rs_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);
    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued ALU-class ops until both operands arrive,
// snoops ALU/LSB results, and dispatches the lowest-index ready entry each cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_i,
    input  logic                 clr_i,
    reservation_station_if.slave bus
);
    localparam int CNT_W = RS_IDX_W + 1;

    rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;
    disp_t                   disp_q, disp_d;
    logic                    out_en_q, out_en_d;

    logic [RS_SIZE-1:0]  busy, ready;
    logic [RS_IDX_W-1:0] free_idx, disp_idx;
    logic                free_found, disp_found;
    logic [CNT_W-1:0]    free_cnt;
    bcast_t              alu_bc, lsb_bc;
    opnd_t               in_rs1, in_rs2;

    for (genvar i = 0; i < RS_SIZE; i++) begin : g_flags
        assign busy[i]  = ent_q[i].busy;
        assign ready[i] = ent_q[i].busy && !ent_q[i].rs1.rely && !ent_q[i].rs2.rely;
    end

    rs_prio_enc #(.N(RS_SIZE)) u_free_sel (.vec_i(~busy), .idx_o(free_idx), .found_o(free_found));
    rs_prio_enc #(.N(RS_SIZE)) u_disp_sel (.vec_i(ready), .idx_o(disp_idx), .found_o(disp_found));

    assign alu_bc = '{en: bus.alu_broadcast_enable, rob_pos: bus.alu_broadcast_rob_pos,
                      val: bus.alu_broadcast_val};
    assign lsb_bc = '{en: bus.lsb_broadcast_enable, rob_pos: bus.lsb_broadcast_rob_pos,
                      val: bus.lsb_broadcast_val};
    assign in_rs1 = snoop('{rely: bus.issue_rs1_rely, tag: bus.issue_rs1_tag,
                            val: bus.issue_rs1_val}, alu_bc, lsb_bc);
    assign in_rs2 = snoop('{rely: bus.issue_rs2_rely, tag: bus.issue_rs2_tag,
                            val: bus.issue_rs2_val}, alu_bc, lsb_bc);

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) free_cnt = free_cnt + CNT_W'(!busy[i]);
    end

    // Keeping one spare slot covers an issuer whose enable is a cycle behind rs_full.
    assign bus.rs_full = (free_cnt <= CNT_W'(1));

    // Dispatch and free-slot choices both come from registered state, so a slot
    // freed this cycle and a slot filled this cycle never collide.
    always_comb begin
        ent_d    = ent_q;
        disp_d   = disp_q;
        out_en_d = out_en_q;
        if (rdy_i) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].rs1 = snoop(ent_q[i].rs1, alu_bc, lsb_bc);
                ent_d[i].rs2 = snoop(ent_q[i].rs2, alu_bc, lsb_bc);
            end
            out_en_d = disp_found;
            if (disp_found) begin
                disp_d = '{op: ent_q[disp_idx].op, rob_pos: ent_q[disp_idx].rob_pos,
                           rs1_val: ent_q[disp_idx].rs1.val, rs2_val: ent_q[disp_idx].rs2.val,
                           imm: ent_q[disp_idx].imm, pc: ent_q[disp_idx].pc};
                ent_d[disp_idx].busy = FALSE;
            end
            if (bus.issue_enable && free_found) begin
                ent_d[free_idx] = '{busy: TRUE, op: bus.issue_openum, rob_pos: bus.issue_rob_pos,
                                    rs1: in_rs1, rs2: in_rs2, imm: bus.issue_imm,
                                    pc: bus.issue_pc};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (clr_i && rdy_i)) begin
            ent_q    <= '0;
            disp_q   <= '0;
            out_en_q <= FALSE;
        end else begin
            ent_q    <= ent_d;
            disp_q   <= disp_d;
            out_en_q <= out_en_d;
        end
    end

    assign bus.rs_to_alu_enable  = out_en_q;
    assign bus.rs_to_alu_openum  = disp_q.op;
    assign bus.rs_to_alu_rob_pos = disp_q.rob_pos;
    assign bus.rs_to_alu_rs1_val = disp_q.rs1_val;
    assign bus.rs_to_alu_rs2_val = disp_q.rs2_val;
    assign bus.rs_to_alu_imm     = disp_q.imm;
    assign bus.rs_to_alu_pc      = disp_q.pc;

    // An issue into a full station is silently dropped in hardware.
    a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
        (rdy_i && !clr_i && bus.issue_enable) |-> free_found);
endmodule

// File: tb/tb_reservation_station.sv
// Directed plus randomized bench for reservation_station against a slot-level model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy, clr;
    reservation_station_if bif();

    reservation_station dut (.clk(clk), .rst(rst), .rdy_i(rdy), .clr_i(clr), .bus(bif));

    always #5 clk = ~clk;

    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit [4:0]  rob;
        bit        p1, p2;
        bit [4:0]  t1, t2;
        bit [31:0] v1, v2, imm, pc;
    } slot_t;

    slot_t     m [RS_SIZE];
    bit        m_en;
    bit [5:0]  m_op;
    bit [4:0]  m_rob;
    bit [31:0] m_v1, m_v2, m_imm, m_pc;
    int        checks = 0, errors = 0;
    string     phase = "init";

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic int first_free();
        foreach (m[i]) if (!m[i].busy) return i;
        return -1;
    endfunction

    function automatic int first_ready();
        foreach (m[i]) if (m[i].busy && !m[i].p1 && !m[i].p2) return i;
        return -1;
    endfunction

    function automatic int free_count();
        int n = 0;
        foreach (m[i]) if (!m[i].busy) n++;
        return n;
    endfunction

    // Returns {still_pending, value} for an operand seen against this cycle's buses.
    function automatic bit [32:0] wake(bit p, bit [4:0] t, bit [31:0] v);
        if (p && bif.alu_broadcast_enable && bif.alu_broadcast_rob_pos == t)
            return {1'b0, bif.alu_broadcast_val};
        if (p && bif.lsb_broadcast_enable && bif.lsb_broadcast_rob_pos == t)
            return {1'b0, bif.lsb_broadcast_val};
        return {p, v};
    endfunction

    task automatic model_step();
        int d, f;
        if (rst || (clr && rdy)) begin
            foreach (m[i]) m[i].busy = 0;
            m_en = 0; m_op = 0; m_rob = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0;
        end else if (rdy) begin
            d = first_ready();
            f = first_free();
            foreach (m[i]) if (m[i].busy) begin
                {m[i].p1, m[i].v1} = wake(m[i].p1, m[i].t1, m[i].v1);
                {m[i].p2, m[i].v2} = wake(m[i].p2, m[i].t2, m[i].v2);
            end
            m_en = (d >= 0);
            if (d >= 0) begin
                m_op = m[d].op; m_rob = m[d].rob; m_v1 = m[d].v1; m_v2 = m[d].v2;
                m_imm = m[d].imm; m_pc = m[d].pc;
                m[d].busy = 0;
            end
            if (bif.issue_enable && f >= 0) begin
                m[f].busy = 1; m[f].op = bif.issue_openum; m[f].rob = bif.issue_rob_pos;
                m[f].t1 = bif.issue_rs1_tag; m[f].t2 = bif.issue_rs2_tag;
                {m[f].p1, m[f].v1} = wake(bif.issue_rs1_rely, bif.issue_rs1_tag, bif.issue_rs1_val);
                {m[f].p2, m[f].v2} = wake(bif.issue_rs2_rely, bif.issue_rs2_tag, bif.issue_rs2_val);
                m[f].imm = bif.issue_imm; m[f].pc = bif.issue_pc;
            end
        end
    endtask

    task automatic set_idle();
        bif.issue_enable = 0; bif.issue_openum = '0; bif.issue_rob_pos = '0;
        bif.issue_rs1_rely = 0; bif.issue_rs1_tag = '0; bif.issue_rs1_val = '0;
        bif.issue_rs2_rely = 0; bif.issue_rs2_tag = '0; bif.issue_rs2_val = '0;
        bif.issue_imm = '0; bif.issue_pc = '0;
        bif.alu_broadcast_enable = 0; bif.alu_broadcast_rob_pos = '0; bif.alu_broadcast_val = '0;
        bif.lsb_broadcast_enable = 0; bif.lsb_broadcast_rob_pos = '0; bif.lsb_broadcast_val = '0;
        clr = 0;
    endtask

    task automatic set_issue(bit [5:0] op, bit [4:0] rob, bit p1, bit [4:0] t1, bit [31:0] v1,
                             bit p2, bit [4:0] t2, bit [31:0] v2, bit [31:0] imm, bit [31:0] pc);
        bif.issue_enable = 1; bif.issue_openum = op; bif.issue_rob_pos = rob;
        bif.issue_rs1_rely = p1; bif.issue_rs1_tag = t1; bif.issue_rs1_val = v1;
        bif.issue_rs2_rely = p2; bif.issue_rs2_tag = t2; bif.issue_rs2_val = v2;
        bif.issue_imm = imm; bif.issue_pc = pc;
    endtask

    task automatic set_alu(bit [4:0] t, bit [31:0] v);
        bif.alu_broadcast_enable = 1; bif.alu_broadcast_rob_pos = t; bif.alu_broadcast_val = v;
    endtask

    task automatic set_lsb(bit [4:0] t, bit [31:0] v);
        bif.lsb_broadcast_enable = 1; bif.lsb_broadcast_rob_pos = t; bif.lsb_broadcast_val = v;
    endtask

    // One clock: advance the model on the driven inputs, then compare every output.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("en",   32'(bif.rs_to_alu_enable),  32'(m_en));
        chk("op",   32'(bif.rs_to_alu_openum),  32'(m_op));
        chk("rob",  32'(bif.rs_to_alu_rob_pos), 32'(m_rob));
        chk("rs1",  bif.rs_to_alu_rs1_val, m_v1);
        chk("rs2",  bif.rs_to_alu_rs2_val, m_v2);
        chk("imm",  bif.rs_to_alu_imm, m_imm);
        chk("pc",   bif.rs_to_alu_pc, m_pc);
        chk("full", 32'(bif.rs_full), 32'(free_count() <= 1));
        set_idle();
    endtask

    initial begin
        bit [4:0] ta, tl;
        rst = 1; rdy = 1;
        set_idle();

        phase = "reset";
        cycle(); cycle();
        chk("en0", 32'(bif.rs_to_alu_enable), 0);
        chk("rs1_0", bif.rs_to_alu_rs1_val, 0);
        chk("pc0", bif.rs_to_alu_pc, 0);
        chk("full0", 32'(bif.rs_full), 0);
        rst = 0;

        phase = "single";
        set_issue(OPENUM_ADDI, 5'd3, 0, 5'd0, 32'd5, 0, 5'd0, 32'd0, 32'd7, 32'h100);
        cycle(); chk("en_issue_edge", 32'(bif.rs_to_alu_enable), 0);
        cycle();
        chk("en", 32'(bif.rs_to_alu_enable), 1);
        chk("rs1", bif.rs_to_alu_rs1_val, 5);
        chk("imm", bif.rs_to_alu_imm, 7);
        chk("rob", 32'(bif.rs_to_alu_rob_pos), 3);
        cycle(); chk("en_after", 32'(bif.rs_to_alu_enable), 0);

        phase = "wakeup";
        set_issue(OPENUM_ADD, 5'd6, 1, 5'd9, 32'd0, 0, 5'd0, 32'd1, 32'd0, 32'h104);
        cycle();
        repeat (3) begin cycle(); chk("hold", 32'(bif.rs_to_alu_enable), 0); end
        set_alu(5'd9, 32'h10);
        cycle(); chk("en_C", 32'(bif.rs_to_alu_enable), 0);
        cycle();
        chk("en_C1", 32'(bif.rs_to_alu_enable), 1);
        chk("rs1", bif.rs_to_alu_rs1_val, 32'h10);
        chk("rs2", bif.rs_to_alu_rs2_val, 32'd1);
        cycle();

        phase = "forward";
        set_issue(OPENUM_BEQ, 5'd7, 0, 5'd0, 32'd3, 1, 5'd4, 32'd0, 32'h20, 32'h108);
        set_lsb(5'd4, 32'hAA);
        cycle(); chk("en_issue_edge", 32'(bif.rs_to_alu_enable), 0);
        cycle();
        chk("en", 32'(bif.rs_to_alu_enable), 1);
        chk("rs2", bif.rs_to_alu_rs2_val, 32'hAA);
        cycle();

        phase = "fill";
        for (int k = 0; k < 15; k++) begin
            set_issue(OPENUM_ADD, 5'(k), 1, 5'd31, 32'd0, 0, 5'd0, 32'(k), 32'(k), 32'h200 + 32'(4 * k));
            cycle();
            chk("full_k", 32'(bif.rs_full), 32'(k == 14));
        end
        set_alu(5'd31, 32'h55);
        cycle(); chk("en_bc_edge", 32'(bif.rs_to_alu_enable), 0);
        for (int k = 0; k < 15; k++) begin
            cycle();
            chk("drain_en", 32'(bif.rs_to_alu_enable), 1);
            chk("drain_rob", 32'(bif.rs_to_alu_rob_pos), 32'(k));
        end
        cycle(); chk("drain_done", 32'(bif.rs_to_alu_enable), 0);

        phase = "flush";
        for (int k = 0; k < 4; k++) begin
            set_issue(OPENUM_SUB, 5'(16 + k), 1, 5'(20 + k), 32'd0, 0, 5'd0, 32'd9, 32'd0, 32'h300);
            cycle();
        end
        set_issue(OPENUM_ADD, 5'd24, 0, 5'd0, 32'd1, 0, 5'd0, 32'd2, 32'd0, 32'h310);
        clr = 1;
        cycle();
        chk("en_clr", 32'(bif.rs_to_alu_enable), 0);
        chk("full_clr", 32'(bif.rs_full), 0);
        set_alu(5'd20, 32'h1); set_lsb(5'd21, 32'h2); cycle();
        set_alu(5'd22, 32'h3); set_lsb(5'd23, 32'h4); cycle();
        repeat (2) begin cycle(); chk("en_stale", 32'(bif.rs_to_alu_enable), 0); end

        phase = "stall";
        set_issue(OPENUM_ADD, 5'd12, 1, 5'd12, 32'd0, 0, 5'd0, 32'd0, 32'd0, 32'h400);
        cycle();
        set_issue(OPENUM_JAL, 5'd13, 0, 5'd0, 32'hC, 0, 5'd0, 32'hD, 32'hE, 32'h404);
        cycle();
        rdy = 0;
        set_alu(5'd12, 32'h77);
        cycle(); chk("stall1", 32'(bif.rs_to_alu_enable), 0);
        cycle(); chk("stall2", 32'(bif.rs_to_alu_enable), 0);
        rdy = 1;
        cycle();
        chk("resume_en", 32'(bif.rs_to_alu_enable), 1);
        chk("resume_rob", 32'(bif.rs_to_alu_rob_pos), 13);
        cycle(); chk("lost_bc", 32'(bif.rs_to_alu_enable), 0);
        set_alu(5'd12, 32'h78);
        cycle(); cycle();
        chk("rewake_en", 32'(bif.rs_to_alu_enable), 1);
        chk("rewake_rs1", bif.rs_to_alu_rs1_val, 32'h78);

        phase = "random";
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) != 0 && free_count() >= 1) begin
                ta = 5'($urandom_range(0, 3)) | ($urandom_range(0, 1) != 0 ? 5'd16 : 5'd0);
                tl = 5'($urandom_range(0, 3)) | ($urandom_range(0, 1) != 0 ? 5'd16 : 5'd0);
                set_issue(6'($urandom), 5'($urandom), 1'($urandom), ta, $urandom,
                          1'($urandom), tl, $urandom, $urandom, $urandom);
            end
            ta = 5'($urandom_range(0, 3)) | ($urandom_range(0, 1) != 0 ? 5'd16 : 5'd0);
            tl = 5'($urandom_range(0, 3)) | ($urandom_range(0, 1) != 0 ? 5'd16 : 5'd0);
            if ($urandom_range(0, 2) == 0) set_alu(ta, $urandom);
            if ($urandom_range(0, 2) == 0 && !(bif.alu_broadcast_enable && tl == ta))
                set_lsb(tl, $urandom);
            if ($urandom_range(0, 59) == 0) clr = 1;
            cycle();
        end
        rdy = 1;
        for (int c = 0; c < 40; c++) begin
            set_alu(5'(c % 4), 32'(c));
            set_lsb(5'(16 + c % 4), 32'(c + 100));
            cycle();
        end
        chk("empty_at_end", 32'(free_count()), RS_SIZE);
        chk("full_at_end", 32'(bif.rs_full), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
